// File: rtl/mem_check_pkg.sv
// Shared constants and FSM state type for the SRAM read-back checker.
package mem_check_pkg;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = AW + 1;

  localparam logic [15:0] SEED = 16'h0001;
  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_readback_checker_if.sv
// SRAM read port bundle between the checker (master) and the memory (slave).
interface mem_readback_checker_if;
  import mem_check_pkg::*;

  logic          mem_ceb;
  logic          mem_web;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_q;

  modport master (
    output mem_ceb,
    output mem_web,
    output mem_a,
    input  mem_q
  );

  modport slave (
    input  mem_ceb,
    input  mem_web,
    input  mem_a,
    output mem_q
  );

endinterface

// File: rtl/chk_prbs16.sv
// 16-bit Fibonacci LFSR regenerating the writer's PRBS sequence.
module chk_prbs16 #(
  parameter logic [15:0] SEED = 16'h0001,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Reload wins over advance; feedback is the parity of the tapped bits.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (en) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & TAPS)};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/mem_readback_checker.sv
// Reads every SRAM word back and compares it against the regenerated
// {prbs, prbs} pattern, reporting error count and first failing address.
module mem_readback_checker
  import mem_check_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  mem_readback_checker_if.master mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CW-1:0]         err_count,
  output logic                  first_fail_valid,
  output logic [AW-1:0]         first_fail_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] MAX_ERR   = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic          mem_ceb_q, mem_ceb_d;
  logic          rd_vld_q, rd_vld_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [CW-1:0] err_count_q, err_count_d;
  logic          ffv_q, ffv_d;
  logic [AW-1:0] ffa_q, ffa_d;

  logic          prbs_load_c;
  logic          prbs_en_c;
  logic [15:0]   prbs_c;
  logic          mismatch_c;

  chk_prbs16 #(
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_prbs (
    .clk  (clk),
    .rst  (rst),
    .load (prbs_load_c),
    .en   (prbs_en_c),
    .q    (prbs_c)
  );

  // Read data is only looked at when the valid bit marks it as a real read.
  assign mismatch_c = rd_vld_q && (mem.mem_q != {prbs_c, prbs_c});

  // Next-state, address sequencing, compare bookkeeping and result updates.
  always_comb begin
    state_d     = state_q;
    mem_a_d     = mem_a_q;
    mem_ceb_d   = mem_ceb_q;
    rd_vld_d    = ~mem_ceb_q;
    cmp_addr_d  = cmp_addr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    ffv_d       = ffv_q;
    ffa_d       = ffa_q;
    prbs_load_c = 1'b0;
    prbs_en_c   = 1'b0;

    if (rd_vld_q) begin
      prbs_en_c  = 1'b1;
      cmp_addr_d = cmp_addr_q + AW'(1);
      if (mismatch_c) begin
        if (err_count_q != MAX_ERR) begin
          err_count_d = err_count_q + CW'(1);
        end
        if (!ffv_q) begin
          ffv_d = 1'b1;
          ffa_d = cmp_addr_q;
        end
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = READ;
          mem_a_d     = '0;
          mem_ceb_d   = 1'b0;
          cmp_addr_d  = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = '0;
          ffv_d       = 1'b0;
          ffa_d       = '0;
          prbs_load_c = 1'b1;
        end
      end
      READ: begin
        if (mem_a_q == LAST_ADDR) begin
          state_d   = DRAIN;
          mem_ceb_d = 1'b1;
        end else begin
          mem_a_d = mem_a_q + AW'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_count_d == '0);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_a_q     <= '0;
      mem_ceb_q   <= 1'b1;
      rd_vld_q    <= 1'b0;
      cmp_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      ffv_q       <= 1'b0;
      ffa_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_a_q     <= mem_a_d;
      mem_ceb_q   <= mem_ceb_d;
      rd_vld_q    <= rd_vld_d;
      cmp_addr_q  <= cmp_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      ffv_q       <= ffv_d;
      ffa_q       <= ffa_d;
    end
  end

  assign mem.mem_ceb       = mem_ceb_q;
  assign mem.mem_web       = 1'b1;
  assign mem.mem_a         = mem_a_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign err_count         = err_count_q;
  assign first_fail_valid  = ffv_q;
  assign first_fail_addr   = ffa_q;

endmodule

// File: tb/tb_mem_readback_checker.sv
// Bench for mem_readback_checker: SRAM model plus a reference that derives
// expected results straight from memory contents versus the golden pattern.
module tb_mem_readback_checker;
  import mem_check_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic          first_fail_valid;
  logic [AW-1:0] first_fail_addr;

  mem_readback_checker_if mem_if();

  mem_readback_checker dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mem              (mem_if),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_addr  (first_fail_addr)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_arr [DEPTH];
  logic [DW-1:0] gold    [DEPTH];

  int checks   = 0;
  int failures = 0;

  // Synchronous-read SRAM; garbage on the output whenever it is not enabled.
  always @(posedge clk) begin
    if (!mem_if.mem_ceb) mem_if.mem_q <= mem_arr[mem_if.mem_a];
    else                 mem_if.mem_q <= $urandom;
  end

  // Golden words: PRBS16 x^16+x^14+x^13+x^11+1 from seed 1, duplicated.
  function automatic void build_gold();
    logic [15:0] p;
    p = 16'h0001;
    for (int k = 0; k < DEPTH; k++) begin
      gold[k] = {p, p};
      p = {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
    end
  endfunction

  function automatic void load_clean();
    for (int k = 0; k < DEPTH; k++) mem_arr[k] = gold[k];
  endfunction

  // Expected outcome computed directly from the memory image.
  function automatic void model(output int errs, output logic ffv, output int ffa);
    errs = 0; ffv = 1'b0; ffa = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (mem_arr[k] != gold[k]) begin
        if (!ffv) begin ffv = 1'b1; ffa = k; end
        errs++;
      end
    end
  endfunction

  // Pulse start and count cycles until done; lat=-1 if it never arrives.
  task automatic run_check(input bit extra, output int lat);
    lat = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (extra && (c == 5 || c == 10)) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, err_count, first_fail_valid, first_fail_addr, mem_if.mem_a} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%0b done=%0b pass=%0b err=%0d ffv=%0b ffa=%0d a=%0d required all 0",
               busy, done, pass, err_count, first_fail_valid, first_fail_addr, mem_if.mem_a);
    end
    checks++;
    if ({mem_if.mem_ceb, mem_if.mem_web} !== 2'b11) begin
      failures++;
      $display("FAIL reset_strobes ceb=%0b web=%0b required 1 1", mem_if.mem_ceb, mem_if.mem_web);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_ignored busy=%0b required 0", busy);
    end
  endtask

  task automatic test_clean_walk();
    int bad_a, done_at;
    load_clean();
    bad_a = 0; done_at = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({mem_if.mem_a, mem_if.mem_ceb, busy} !== {AW'(0), 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL start_edge a=%0d ceb=%0b busy=%0b required 0 0 1", mem_if.mem_a, mem_if.mem_ceb, busy);
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c <= 31 && mem_if.mem_a !== AW'(c)) bad_a++;
      if (c == 32 && (mem_if.mem_a !== AW'(31) || mem_if.mem_ceb !== 1'b1)) bad_a++;
      if (done && done_at < 0) done_at = c;
    end
    checks++;
    if (bad_a != 0) begin
      failures++;
      $display("FAIL addr_walk bad_cycles=%0d required 0", bad_a);
    end
    checks++;
    if (done_at != 33) begin
      failures++;
      $display("FAIL clean_latency got=%0d required 33", done_at);
    end
    checks++;
    if ({pass, err_count, first_fail_valid, busy} !== {1'b1, 6'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clean_result pass=%0b err=%0d ffv=%0b busy=%0b required 1 0 0 0",
               pass, err_count, first_fail_valid, busy);
    end
  endtask

  task automatic test_errors(input string name, input bit extra);
    int lat, errs, ffa;
    logic ffv;
    model(errs, ffv, ffa);
    run_check(extra, lat);
    checks++;
    if (lat != 33) begin
      failures++;
      $display("FAIL %s_latency got=%0d required 33", name, lat);
    end
    checks++;
    if (err_count !== (AW+1)'(errs) || pass !== (errs == 0)) begin
      failures++;
      $display("FAIL %s_count err=%0d pass=%0b required err=%0d pass=%0b",
               name, err_count, pass, errs, (errs == 0));
    end
    checks++;
    if (first_fail_valid !== ffv || first_fail_addr !== AW'(ffa)) begin
      failures++;
      $display("FAIL %s_first ffv=%0b ffa=%0d required ffv=%0b ffa=%0d",
               name, first_fail_valid, first_fail_addr, ffv, ffa);
    end
  endtask

  task automatic test_single_bit();
    load_clean();
    mem_arr[7][5] = ~mem_arr[7][5];
    test_errors("bit5_addr7", 1'b0);
  endtask

  task automatic test_two_errors();
    load_clean();
    mem_arr[3]  = mem_arr[3] ^ 32'h0001_0000;
    mem_arr[20] = mem_arr[20] ^ 32'h8000_0000;
    test_errors("addr3_addr20", 1'b0);
  endtask

  task automatic test_all_zero();
    for (int k = 0; k < DEPTH; k++) mem_arr[k] = '0;
    test_errors("all_zero", 1'b0);
  endtask

  task automatic test_back_to_back();
    load_clean();
    mem_arr[11] = ~mem_arr[11];
    test_errors("extra_starts", 1'b1);
    load_clean();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({done, busy, err_count} !== {1'b0, 1'b1, 6'd0}) begin
      failures++;
      $display("FAIL restart_clear done=%0b busy=%0b err=%0d required 0 1 0", done, busy, err_count);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if ({done, pass, err_count} !== {1'b1, 1'b1, 6'd0}) begin
      failures++;
      $display("FAIL restart_result done=%0b pass=%0b err=%0d required 1 1 0", done, pass, err_count);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    load_clean();
    for (int k = 0; k < 3; k++) mem_arr[k] = ~mem_arr[k];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (err_count !== 6'd3) begin
      failures++;
      $display("FAIL mid_pre_reset err=%0d required 3", err_count);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, err_count, first_fail_valid, mem_if.mem_ceb} !== {1'b0, 1'b0, 6'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mid_reset busy=%0b done=%0b err=%0d ffv=%0b ceb=%0b required 0 0 0 0 1",
               busy, done, err_count, first_fail_valid, mem_if.mem_ceb);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_done done=%0b required 0", done);
    end
    load_clean();
    run_check(1'b0, lat);
    checks++;
    if (lat != 33 || pass !== 1'b1 || err_count !== 6'd0) begin
      failures++;
      $display("FAIL post_reset_run lat=%0d pass=%0b err=%0d required 33 1 0", lat, pass, err_count);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      load_clean();
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) begin
        int a;
        logic [DW-1:0] m;
        a = $urandom_range(0, DEPTH - 1);
        m = $urandom;
        if (m == '0) m = 32'h0000_0100;
        mem_arr[a] = mem_arr[a] ^ m;
      end
      test_errors($sformatf("random%0d", it), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    build_gold();
    load_clean();
    test_reset();
    test_clean_walk();
    test_single_bit();
    test_two_errors();
    test_all_zero();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_readback_checker.md
Name: mem_readback_checker

Overview:
- Read-side companion to the PRBS memory write/BIST path. After the writer fills the 32x32 SRAM with {prbs, prbs} words, this block reads every address back.
- It regenerates the same PRBS16 sequence locally and compares each word directly instead of compressing into a signature.
- It reports pass/fail, an error count and the first failing address, so failures are localised rather than only detected.

Parameters:
- DEPTH, 32, number of words checked; addresses 0..DEPTH-1.
- AW, 5, address width (clog2(DEPTH)).
- DW, 32, memory data width; expected word = {prbs, prbs}.
- SEED, 16'h0001, PRBS16 load value; must equal the writer's PRBS reset value.
- TAPS, 16'hB400, Fibonacci feedback taps (x^16+x^14+x^13+x^11+1); must equal the writer's polynomial.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a check; sampled only in IDLE.
- mem_ceb  out  1  SRAM chip enable, active low.
- mem_web  out  1  SRAM write enable, active low; tied 1 (read only).
- mem_a  out  AW  SRAM address, registered.
- mem_q  in  DW  SRAM read data; valid the cycle after the address edge.
- busy  out  1  check in progress.
- done  out  1  sticky; high from completion until the next accepted start or rst.
- pass  out  1  valid while done; 1 iff err_count==0.
- err_count  out  AW+1  number of mismatching words.
- first_fail_valid  out  1  at least one mismatch seen.
- first_fail_addr  out  AW  address of the first mismatch.

Behaviour:
- Reset values: all outputs 0 except mem_ceb=1 and mem_web=1. FSM goes to IDLE, PRBS loads SEED.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start at edge E0 → READ. Same edge: mem_a=0, mem_ceb=0, busy=1, done=0, pass=0, err_count=0, first_fail_* cleared, PRBS reloaded to SEED.
  - READ: the SRAM samples address k at edge E(k+1). mem_a increments each cycle. When mem_a==DEPTH-1 has been issued, go to DRAIN and set mem_ceb=1.
  - DRAIN: one cycle for the final compare, then DONE.
  - DONE: done=1, busy=0, pass=(err_count==0). start → same actions as in IDLE. DONE behaves as IDLE for restart.
- Compare timing:
  - A pipeline valid bit marks cycles where mem_q is meaningful.
  - At edge E(k+2), mem_q is compared combinationally against {exp, exp}, where exp is the PRBS state after k advances from SEED.
  - The PRBS advances exactly once per compared word.
- Latency: start edge E0 to done visible after E(DEPTH+1), i.e. 33 cycles for DEPTH=32.
- On a mismatch:
  - err_count increments, saturating at DEPTH; it cannot overflow with width AW+1.
  - On the first mismatch only, first_fail_addr=k and first_fail_valid=1.
- No wrap: mem_a stops at DEPTH-1 and is held.
- start while busy is ignored with no side effect. start in the same cycle as rst: rst wins.
- rst mid-operation: immediate return to IDLE, all results cleared, no done pulse.
- mem_q is ignored (X-tolerant) when the valid bit is low.

Decomposition:
- Package mem_check_pkg:
  - state enum typedef {IDLE, READ, DRAIN, DONE};
  - default constants DEPTH, AW, DW, SEED, TAPS.
- One sub-module, chk_prbs16: 16-bit Fibonacci LFSR.
  - Ports clk, rst, load, en, q.
  - Synchronous load of SEED; advances on en.
  - Parameters SEED, TAPS.

Test Plan:
- Memory model preloaded with the correct {prbs, prbs} sequence from SEED=1, start pulse → mem_a walks 0..31, done rises 33 cycles after start, pass=1, err_count=0, first_fail_valid=0.
- Flip bit 5 of the word at address 7 → pass=0, err_count=1, first_fail_addr=7, first_fail_valid=1.
- Corrupt addresses 3 and 20 (upper half only at 20) → err_count=2, first_fail_addr=3; done timing unchanged.
- All 32 words zeroed → err_count=32 (no wrap), first_fail_addr=0, pass=0.
- Extra start pulses at cycles 5 and 10 of a run → ignored, single run, done still at cycle 33. Then a new start from DONE with clean memory → done clears for the run, then pass=1, err_count=0.
- rst asserted at cycle 12 of a run with errors already counted → next cycle busy=0, err_count=0, first_fail_valid=0, mem_ceb=1. A subsequent start runs a clean full check.
